stream_reducer: RTL and testbench

Sequential controller that sums a variable-length stream of WIDTH-bit elements by sharing one combinational `adder_tree` instance (N inputs). Elements are collected over a valid/ready input handshake into an N-slot batch buffer. Each full or final batch goes through the tree in one cycle and is folded into a running accumulator. At end of frame, the total and element count are presented on a valid/ready output. The block sits between a data producer and any consumer needing per-frame sums.

---
 rtl/stream_reducer.sv | 124 ++++++++++++
 tb/tb_stream_reducer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/stream_reducer.sv
// stream_reducer: per-frame stream summation through a shared N-input adder tree.
// Optional macro STREAM_REDUCER_SAT_EN: saturating accumulator plus sticky out_sat flag.

// adder_tree: combinational binary reduction of N values (N a power of two).
module adder_tree #(
  parameter int WIDTH = 16,
  parameter int N     = 4
) (
  input  logic [N-1:0][WIDTH-1:0] i_data,
  output logic [WIDTH-1:0]        o_sum
);
  // Heap-ordered nodes: leaves at N..2N-1, node k sums children 2k and 2k+1, root at 1.
  logic [WIDTH-1:0] w_node [2*N-1:1];
  genvar k;
  for (k = 1; k < 2*N; k++) begin : g_node
    if (k >= N) begin : g_leaf
      assign w_node[k] = i_data[k-N];
    end else begin : g_add
      assign w_node[k] = w_node[2*k] + w_node[2*k+1];
    end
  end
  assign o_sum = w_node[1];
endmodule

module stream_reducer #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int ACC_W = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count
`ifdef STREAM_REDUCER_SAT_EN
  ,
  output logic             out_sat
`endif
);
  localparam int IW = $clog2(N);
  localparam logic [1:0] S_FILL = 2'd0;
  localparam logic [1:0] S_RED  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  logic [1:0]             r_state;
  logic [IW-1:0]          r_idx;
  logic [N-1:0][WIDTH-1:0] r_slot;
  logic [ACC_W-1:0]       r_acc;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_last;
  logic [N-1:0][ACC_W-1:0] w_tree_in;
  logic [ACC_W-1:0]       w_tree_sum;
  logic [ACC_W-1:0]       w_acc_next;

  genvar i;
  for (i = 0; i < N; i++) begin : g_ext
    assign w_tree_in[i] = {{(ACC_W-WIDTH){1'b0}}, r_slot[i]};
  end

  adder_tree #(.WIDTH(ACC_W), .N(N)) u_tree (
    .i_data(w_tree_in),
    .o_sum (w_tree_sum)
  );

`ifdef STREAM_REDUCER_SAT_EN
  logic [ACC_W:0] w_wide;
  logic           r_sat;
  // Carry out of the widened add means the frame total no longer fits; clamp to all ones.
  always_comb begin
    w_wide     = {1'b0, r_acc} + {1'b0, w_tree_sum};
    w_acc_next = w_wide[ACC_W] ? '1 : w_wide[ACC_W-1:0];
  end
  // Sticky per-frame saturation flag, cleared when the result is taken.
  always_ff @(posedge clk) begin
    if (rst) r_sat <= 1'b0;
    else if (r_state == S_RED && w_wide[ACC_W]) r_sat <= 1'b1;
    else if (r_state == S_OUT && out_ready) r_sat <= 1'b0;
  end
  assign out_sat = r_sat;
`else
  assign w_acc_next = r_acc + w_tree_sum;
`endif

  // Collect a batch, fold it through the tree, then hold the frame result until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FILL;
      r_idx   <= '0;
      r_slot  <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_last  <= 1'b0;
    end else if (r_state == S_FILL) begin
      if (in_valid) begin
        r_slot[r_idx] <= in_data;
        r_idx         <= r_idx + IW'(1);
        r_cnt         <= r_cnt + CNT_W'(1);
        r_last        <= in_last;
        if (r_idx == IW'(N-1) || in_last) r_state <= S_RED;
      end
    end else if (r_state == S_RED) begin
      r_acc   <= w_acc_next;
      r_slot  <= '0;
      r_idx   <= '0;
      r_state <= r_last ? S_OUT : S_FILL;
    end else if (out_ready) begin
      r_acc   <= '0;
      r_cnt   <= '0;
      r_last  <= 1'b0;
      r_state <= S_FILL;
    end
  end

  assign in_ready  = (r_state == S_FILL);
  assign out_valid = (r_state == S_OUT);
  assign out_sum   = r_acc;
  assign out_count = r_cnt;
endmodule

// File: tb/tb_stream_reducer.sv
// tb_stream_reducer: directed self-checking bench for stream_reducer.
module tb_stream_reducer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_sum;
  logic [15:0] out_count;
  int          checks = 0;
  int          errors = 0;
`ifdef STREAM_REDUCER_SAT_EN
  logic        out_sat;
`endif

  stream_reducer #(.WIDTH(8), .N(4), .ACC_W(16), .CNT_W(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_count(out_count)
`ifdef STREAM_REDUCER_SAT_EN
    ,
    .out_sat  (out_sat)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Offer one element at a negedge; returns at the negedge after it is accepted.
  task automatic send(input logic [7:0] d, input logic l);
    int n = 0;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("send_timeout", 0, 1);
    @(negedge clk);
  endtask

  // Wait for the result, check it, accept it and check the return to FILL.
  task automatic take(input string tag, input logic [15:0] s, input logic [15:0] c);
    int n = 0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_sum"}, out_sum, s);
    chk({tag, "_count"}, out_count, c);
    chk({tag, "_inrdy_low"}, in_ready, 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_valid_clr"}, out_valid, 0);
    chk({tag, "_inrdy_back"}, in_ready, 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", out_sum, 0);
    chk("rst_count", out_count, 0);

    // 10,20,30,40: result appears exactly two edges after the last accept
    send(10, 0); send(20, 0); send(30, 0); send(40, 1);
    in_valid = 1'b0;
    chk("lat_reduce_cycle", out_valid, 0);
    chk("lat_reduce_inrdy", in_ready, 0);
    @(negedge clk);
    chk("lat_out_cycle", out_valid, 1);
    take("f4", 100, 4);

    // six x 255, continuous valid: one-cycle bubble after the 4th accept
    for (int i = 0; i < 4; i++) send(255, 0);
    chk("bubble_low", in_ready, 0);
    @(negedge clk);
    chk("bubble_one_cycle", in_ready, 1);
    send(255, 0); send(255, 1);
    take("f6", 1530, 6);

    // single element, padded slots read as zero
    send(7, 1);
    take("f1", 7, 1);

    // backpressure on the 1,2,3,4 result
    send(1, 0); send(2, 0); send(3, 0); send(4, 1);
    in_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", out_valid, 1);
      chk("bp_sum", out_sum, 10);
      chk("bp_inrdy", in_ready, 0);
      @(negedge clk);
    end
    take("bp", 10, 4);
    send(5, 0); send(5, 1);
    take("after_bp", 10, 2);

    // overflow: 260 x 255 = 66300
    for (int i = 0; i < 260; i++) send(255, i == 259);
`ifdef STREAM_REDUCER_SAT_EN
    in_valid = 1'b0;
    @(negedge clk);
    chk("ovf_sat_flag", out_sat, 1);
    take("ovf", 16'hFFFF, 260);
    chk("ovf_sat_clr", out_sat, 0);
`else
    take("ovf", 764, 260);
`endif

    // reset mid-frame discards partial state
    send(9, 0); send(9, 0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("midrst_no_valid", out_valid, 0);
      @(negedge clk);
    end
    chk("midrst_count", out_count, 0);
    send(1, 0); send(2, 0); send(3, 1);
    take("post_rst", 6, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
